// File: rtl/echo_pkg.sv
// ============================================================================
// Module      : echo_pkg
// Description : Shared types and helpers for the multi-channel echo capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package echo_pkg;

    localparam int MAX_LENGTH = 32;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        MEAS = 2'd2,
        HOLD = 2'd3
    } ch_state_t;

    typedef struct packed {
        logic [MAX_LENGTH-1:0] width;
        logic                  tflag;
        logic                  ovf;
    } result_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/echo_channel.sv
// ============================================================================
// Module      : echo_channel
// Description : One echo input: synchroniser, width FSM, holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_channel
    import echo_pkg::*;
#(
    parameter int LENGTH      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_in_pulse,
    input  logic [LENGTH-1:0] i_timeout,
    input  logic              i_clr,
    output logic              o_pend,
    output logic              o_ovf,
    output logic [LENGTH-1:0] o_width,
    output logic              o_tflag
);

    localparam logic [LENGTH-1:0] c_one = LENGTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_s;
    logic                   r_p;
    ch_state_t              r_state;
    logic [LENGTH-1:0]      r_cnt;
    logic [LENGTH-1:0]      r_width;
    logic                   r_tflag;
    logic                   r_pend;
    logic                   r_ovf;

    logic                   w_rise;
    logic                   w_cap;
    logic [LENGTH-1:0]      w_cap_width;
    logic                   w_cap_tflag;

    assign w_rise = r_s & ~r_p;

    always_comb begin
        w_cap       = 1'b0;
        w_cap_width = '0;
        w_cap_tflag = 1'b0;
        if (i_en && r_state == MEAS) begin
            if (!r_s) begin
                w_cap       = 1'b1;
                w_cap_width = r_cnt;
            end else if (i_timeout != '0 && r_cnt == i_timeout) begin
                w_cap       = 1'b1;
                w_cap_width = i_timeout;
                w_cap_tflag = 1'b1;
            end else if (&r_cnt) begin
                w_cap       = 1'b1;
                w_cap_width = '1;
                w_cap_tflag = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_s     <= 1'b0;
            r_p     <= 1'b0;
            r_state <= ARM;
            r_cnt   <= '0;
            r_width <= '0;
            r_tflag <= 1'b0;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in_pulse};
            // r_vld tracks when r_s first reflects a real post-reset sample, so
            // ARM is not fooled by the cleared synchroniser.
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_s    <= r_sync[SYNC_STAGES-1];
            r_p    <= r_s;

            if (!i_en) begin
                r_state <= ARM;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ARM:  if (r_vld[SYNC_STAGES] && !r_s) r_state <= IDLE;
                    IDLE: if (w_rise) begin
                        r_cnt   <= c_one;
                        r_state <= MEAS;
                    end
                    // All-ones always captures, so the increment never wraps.
                    MEAS: if (w_cap) r_state <= r_s ? HOLD : IDLE;
                          else       r_cnt   <= r_cnt + c_one;
                    HOLD: if (!r_s) r_state <= IDLE;
                    default: r_state <= ARM;
                endcase
            end

            if (w_cap) begin
                r_width <= w_cap_width;
                r_tflag <= w_cap_tflag;
                r_pend  <= 1'b1;
                r_ovf   <= i_clr ? 1'b0 : (r_ovf | r_pend);
            end else if (i_clr) begin
                r_pend  <= 1'b0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign o_pend  = r_pend;
    assign o_ovf   = r_ovf;
    assign o_width = r_width;
    assign o_tflag = r_tflag;

endmodule

`default_nettype wire

// File: rtl/echo_multi_capture.sv
// ============================================================================
// Module      : echo_multi_capture
// Description : NUM_CH echo width channels, round-robin arbiter, result stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_multi_capture
    import echo_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int LENGTH      = 32,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] in_pulse,
    input  logic [LENGTH-1:0] timeout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [LENGTH-1:0] m_width,
    output logic              m_timeout,
    output logic              m_overrun
);

    localparam logic [CH_W:0] c_num = (CH_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_tflag;
    logic [NUM_CH-1:0] w_clr;
    logic [LENGTH-1:0] w_width [NUM_CH];

    logic              w_load;
    logic              w_found;
    logic [CH_W-1:0]   w_grant;
    logic [CH_W:0]     w_idx;

    logic              r_valid;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_last;
    result_t           r_out;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        echo_channel #(
            .LENGTH      (LENGTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .i_en       (en),
            .i_in_pulse (in_pulse[g]),
            .i_timeout  (timeout),
            .i_clr      (w_clr[g]),
            .o_pend     (w_pend[g]),
            .o_ovf      (w_ovf[g]),
            .o_width    (w_width[g]),
            .o_tflag    (w_tflag[g])
        );
    end

    assign w_load = !r_valid || m_ready;

    // Search starts one past the last grant and wraps modulo NUM_CH.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        w_clr   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = {1'b0, r_last} + (CH_W+1)'(i);
            if (w_idx >= c_num) w_idx = w_idx - c_num;
            if (!w_found && w_pend[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[CH_W-1:0];
            end
        end
        if (w_load && w_found) w_clr[w_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            // Parked on the top channel so channel 0 is first in line after reset.
            r_last  <= CH_W'(NUM_CH - 1);
            r_out   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_ch        <= w_grant;
                r_last      <= w_grant;
                r_out.width <= MAX_LENGTH'(w_width[w_grant]);
                r_out.tflag <= w_tflag[w_grant];
                r_out.ovf   <= w_ovf[w_grant];
            end
        end
    end

    assign m_valid   = r_valid;
    assign m_ch      = r_ch;
    assign m_width   = LENGTH'(r_out.width);
    assign m_timeout = r_out.tflag;
    assign m_overrun = r_out.ovf;

endmodule

`default_nettype wire

// File: tb/tb_echo_multi_capture.sv
// ============================================================================
// Module      : tb_echo_multi_capture
// Description : Scoreboard bench for echo_multi_capture with a pulse-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_echo_multi_capture;

    localparam int NUM_CH = 4;
    localparam int LENGTH = 8;
    localparam int SYNC   = 2;
    localparam int CH_W   = 2;
    localparam int MAXW   = (1 << LENGTH) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NUM_CH-1:0] in_pulse;
    logic [LENGTH-1:0] tmo;
    logic              m_valid;
    logic              m_ready;
    logic [CH_W-1:0]   m_ch;
    logic [LENGTH-1:0] m_width;
    logic              m_timeout;
    logic              m_overrun;

    always #5 clk = ~clk;

    echo_multi_capture #(
        .NUM_CH      (NUM_CH),
        .LENGTH      (LENGTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_pulse  (in_pulse),
        .timeout   (tmo),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_ch      (m_ch),
        .m_width   (m_width),
        .m_timeout (m_timeout),
        .m_overrun (m_overrun)
    );

    typedef struct {
        int ch;
        int width;
        int tflag;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rnd_rdy = 1'b0;

    // Pulse-level model: each channel holds one pending result plus an overrun flag.
    int   mdl_pend [NUM_CH];
    int   mdl_w    [NUM_CH];
    int   mdl_t    [NUM_CH];
    int   mdl_o    [NUM_CH];
    int   mdl_last = NUM_CH - 1;

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void model_capture(input int ch, input int len, input int to);
        int w;
        int t;
        if (to != 0 && len > to) begin
            w = to;
            t = 1;
        end else if (len > MAXW) begin
            w = MAXW;
            t = 1;
        end else begin
            w = len;
            t = 0;
        end
        if (mdl_pend[ch] != 0) mdl_o[ch] = 1;
        mdl_pend[ch] = 1;
        mdl_w[ch]    = w;
        mdl_t[ch]    = t;
    endfunction

    function automatic void model_drain();
        exp_t e;
        for (int n = 0; n < NUM_CH; n++) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (mdl_last + k) % NUM_CH;
                if (mdl_pend[c] != 0) begin
                    e.ch = c; e.width = mdl_w[c]; e.tflag = mdl_t[c]; e.ovf = mdl_o[c];
                    exp_q.push_back(e);
                    mdl_pend[c] = 0;
                    mdl_o[c]    = 0;
                    mdl_last    = c;
                    break;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) begin
            if (!m_ready) m_ready = 1'b1;
            else          m_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask, input int len);
        in_pulse = in_pulse | mask;
        repeat (len) tick();
        in_pulse = in_pulse & ~mask;
    endtask

    task automatic single(input int ch, input int len);
        model_capture(ch, len, int'(tmo));
        model_drain();
        pulse(NUM_CH'(1) << ch, len);
    endtask

    // Monitor: pops on every handshake and checks stability while stalled.
    bit              stall_prev = 1'b0;
    logic [CH_W-1:0] held_ch;
    logic [LENGTH-1:0] held_w;
    logic            held_t;
    logic            held_o;

    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                check("stall_valid", int'(m_valid), 1);
                check("stall_data", int'({m_ch, m_width, m_timeout, m_overrun}),
                      int'({held_ch, held_w, held_t, held_o}));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result_ch", int'(m_ch), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ch", int'(m_ch), e.ch);
                    check("width", int'(m_width), e.width);
                    check("timeout_flag", int'(m_timeout), e.tflag);
                    check("overrun_flag", int'(m_overrun), e.ovf);
                end
            end
            stall_prev = m_valid && !m_ready;
            held_ch = m_ch; held_w = m_width; held_t = m_timeout; held_o = m_overrun;
        end
    end

    initial begin
        int ch;
        int len;
        for (int i = 0; i < NUM_CH; i++) begin
            mdl_pend[i] = 0; mdl_w[i] = 0; mdl_t[i] = 0; mdl_o[i] = 0;
        end
        rst      = 1'b0;
        en       = 1'b1;
        m_ready  = 1'b1;
        tmo      = '0;
        in_pulse = 4'b0001;
        repeat (3) tick();
        check("rst_valid", int'(m_valid), 0);
        check("rst_ch", int'(m_ch), 0);
        check("rst_width", int'(m_width), 0);
        check("rst_timeout", int'(m_timeout), 0);
        check("rst_overrun", int'(m_overrun), 0);

        // Arming: pulse already high at reset release is discarded.
        rst = 1'b1;
        repeat (10) tick();
        in_pulse = '0;
        repeat (5) tick();
        single(0, 10);
        repeat (15) tick();

        // Saturation on ch1.
        single(1, 300);
        repeat (15) tick();

        // Timeout on ch2, then a normal pulse below the timeout.
        tmo = 8'd50;
        single(2, 200);
        repeat (10) tick();
        single(2, 20);
        repeat (15) tick();
        tmo = '0;

        // Enable drop mid-pulse on ch3, then a clean pulse.
        in_pulse[3] = 1'b1;
        repeat (15) tick();
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        repeat (15) tick();
        in_pulse[3] = 1'b0;
        repeat (10) tick();
        single(3, 12);
        repeat (15) tick();

        // Round-robin: simultaneous bursts on ch0, ch1, ch3.
        repeat (2) begin
            model_capture(0, 5, 0);
            model_capture(1, 5, 0);
            model_capture(3, 5, 0);
            model_drain();
            pulse(4'b1011, 5);
            repeat (15) tick();
        end

        // Overrun under backpressure.
        m_ready = 1'b0;
        single(0, 4);
        repeat (10) tick();
        model_capture(1, 7, 0);
        pulse(4'b0010, 7);
        repeat (10) tick();
        model_capture(1, 9, 0);
        pulse(4'b0010, 9);
        repeat (10) tick();
        model_drain();
        m_ready = 1'b1;
        repeat (10) tick();
        single(1, 6);
        repeat (15) tick();

        // Randomised pulses, timeouts and ready stalls.
        rnd_rdy = 1'b1;
        repeat (25) begin
            ch  = $urandom_range(0, NUM_CH - 1);
            len = $urandom_range(1, 300);
            tmo = ($urandom_range(0, 1) != 0) ? LENGTH'($urandom_range(1, MAXW)) : '0;
            single(ch, len);
            repeat ($urandom_range(12, 20)) tick();
        end
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        repeat (20) tick();
        check("results_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
